// File: rtl/ysyx_22050368_pc_gen.sv
// ysyx_22050368_pc_gen: fetch PC generator for the NPC front end.
// Sequential stepping, backend hold, buffered trap/jump redirects.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   hold_i                 backend stall (freeze PC, buffer redirects)
//   jump_i, jump_addr_i    branch/jump redirect pulse and target
//   trap_i, trap_addr_i    trap/mret redirect pulse and target (beats jump)
//   if_ready_i             IFU accepts pc_o this cycle
//   pc_o, pc_valid_o       fetch request
//   flush_o                1-cycle pulse after a redirect is applied
//   misalign_o             1-cycle pulse: applied target had low bits set
module ysyx_22050368_pc_gen #(
   parameter int          ADDR_W     = 64,
   parameter logic [63:0] RST_ADDR   = 64'h8000_0000,
   parameter int          STEP       = 4,
   parameter int          ALIGN_BITS = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              hold_i,
   input  logic              jump_i,
   input  logic [ADDR_W-1:0] jump_addr_i,
   input  logic              trap_i,
   input  logic [ADDR_W-1:0] trap_addr_i,
   input  logic              if_ready_i,
   output logic [ADDR_W-1:0] pc_o,
   output logic              pc_valid_o,
   output logic              flush_o,
   output logic              misalign_o
);

   typedef enum logic [1:0] {
      S_BOOT,
      S_RUN,
      S_PEND
   } state_t;

   localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RST_ADDR);
   localparam logic [ADDR_W-1:0] STEP_W = ADDR_W'(STEP);
   // Bits kept in a redirect target; the rest are forced to zero.
   localparam logic [ADDR_W-1:0] KEEP_MASK = {ADDR_W{1'b1}} << ALIGN_BITS;

   state_t              r_state;
   logic [ADDR_W-1:0]   r_pc;
   logic                r_flush;
   logic                r_mis;
   logic                r_pend_vld;
   logic [ADDR_W-1:0]   r_pend_addr;
   logic                r_pend_trap;

   state_t              w_state_nxt;
   logic [ADDR_W-1:0]   w_pc_nxt;
   logic                w_flush_nxt;
   logic                w_mis_nxt;
   logic                w_pend_vld_nxt;
   logic [ADDR_W-1:0]   w_pend_addr_nxt;
   logic                w_pend_trap_nxt;
   logic                w_new;
   logic [ADDR_W-1:0]   w_new_addr;
   logic [ADDR_W-1:0]   w_tgt;
   logic                w_apply;

   always_comb begin
      w_state_nxt     = r_state;
      w_pc_nxt        = r_pc;
      w_flush_nxt     = 1'b0;
      w_mis_nxt       = 1'b0;
      w_pend_vld_nxt  = r_pend_vld;
      w_pend_addr_nxt = r_pend_addr;
      w_pend_trap_nxt = r_pend_trap;
      w_new           = trap_i | jump_i;
      w_new_addr      = trap_i ? trap_addr_i : jump_addr_i;
      w_tgt           = w_new_addr;
      w_apply         = 1'b0;

      unique case (r_state)
         S_BOOT: begin
            w_state_nxt = S_RUN;
         end
         S_RUN: begin
            if (w_new & ~hold_i) begin
               w_apply = 1'b1;
            end else if (w_new) begin
               w_pend_vld_nxt  = 1'b1;
               w_pend_addr_nxt = w_new_addr;
               w_pend_trap_nxt = trap_i;
               w_state_nxt     = S_PEND;
            end else if (~hold_i & if_ready_i) begin
               w_pc_nxt = r_pc + STEP_W;
            end
         end
         S_PEND: begin
            if (~hold_i & r_pend_vld) begin
               // trap > pending trap > jump > pending jump
               w_apply = 1'b1;
               if (trap_i)
                  w_tgt = trap_addr_i;
               else if (r_pend_trap)
                  w_tgt = r_pend_addr;
               else if (jump_i)
                  w_tgt = jump_addr_i;
               else
                  w_tgt = r_pend_addr;
               w_pend_vld_nxt = 1'b0;
               w_state_nxt    = S_RUN;
            end else if (trap_i) begin
               w_pend_addr_nxt = trap_addr_i;
               w_pend_trap_nxt = 1'b1;
            end else if (jump_i & ~r_pend_trap) begin
               w_pend_addr_nxt = jump_addr_i;
            end
         end
         default: begin
            w_state_nxt = S_BOOT;
         end
      endcase

      if (w_apply) begin
         w_pc_nxt    = w_tgt & KEEP_MASK;
         w_flush_nxt = 1'b1;
         w_mis_nxt   = |(w_tgt & ~KEEP_MASK);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_BOOT;
         r_pc        <= RST_PC;
         r_flush     <= 1'b0;
         r_mis       <= 1'b0;
         r_pend_vld  <= 1'b0;
         r_pend_addr <= '0;
         r_pend_trap <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_pc        <= w_pc_nxt;
         r_flush     <= w_flush_nxt;
         r_mis       <= w_mis_nxt;
         r_pend_vld  <= w_pend_vld_nxt;
         r_pend_addr <= w_pend_addr_nxt;
         r_pend_trap <= w_pend_trap_nxt;
      end
   end

   assign pc_o       = r_pc;
   assign pc_valid_o = (r_state != S_BOOT);
   assign flush_o    = r_flush;
   assign misalign_o = r_mis;

endmodule
